// File: rtl/soc_mon_pkg.sv
// -----------------------------------------------------------------------------
// soc_mon_pkg
//   Shared types and constants for the SoC self-test monitor.
//   mon_state_t  : monitor FSM states (IDLE, RUN, PASS, FAIL)
//   fail_code_t  : failure cause reported on fail_code
//   DBG_ADDR_W   : width of the CPU debug register address
// -----------------------------------------------------------------------------
package soc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        PASS = 2'b10,
        FAIL = 2'b11
    } mon_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_TIMEOUT = 2'b01,
        FC_HALT    = 2'b10
    } fail_code_t;

    localparam int DBG_ADDR_W = 5;

endpackage

// File: rtl/soc_selftest_monitor_if.sv
// -----------------------------------------------------------------------------
// soc_selftest_monitor_if
//   Link between the self-test monitor and the CPU it supervises.
//   cpu_step_en  : one-clk CPU clock enable (monitor -> CPU)
//   dbg_reg_addr : debug register index (monitor -> CPU)
//   dbg_reg_data : debug register read data, combinational (CPU -> monitor)
//   cpu_pc       : current CPU instruction address (CPU -> monitor)
//
// Handshake: there is no backpressure on this link. cpu_step_en acts as a
// single-cycle valid; the CPU advances exactly one step for every clk in which
// it is high and must always accept it (an implicit ready of 1).
// dbg_reg_data and cpu_pc are treated as valid in every clk cycle.
// Modports: master = monitor side, slave = CPU side.
// -----------------------------------------------------------------------------
interface soc_selftest_monitor_if #(
    parameter int DATA_W = 32
);

    logic                               cpu_step_en;
    logic [soc_mon_pkg::DBG_ADDR_W-1:0] dbg_reg_addr;
    logic [DATA_W-1:0]                  dbg_reg_data;
    logic [DATA_W-1:0]                  cpu_pc;

    modport master (
        output cpu_step_en,
        output dbg_reg_addr,
        input  dbg_reg_data,
        input  cpu_pc
    );

    modport slave (
        input  cpu_step_en,
        input  dbg_reg_addr,
        output dbg_reg_data,
        output cpu_pc
    );

endinterface

// File: rtl/soc_mon_step_gen.sv
// -----------------------------------------------------------------------------
// soc_mon_step_gen
//   Clock divider producing the CPU step pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count while high; when low the divider is held at 0
//   step_en    : registered one-clk pulse each time the divider wraps
//   The first pulse appears DIV cycles after enable rises (DIV=1: every clk).
// -----------------------------------------------------------------------------
module soc_mon_step_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic step_en
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          step_en_q, step_en_d;

    always_comb begin
        div_cnt_d = '0;
        step_en_d = 1'b0;
        if (enable) begin
            if (div_cnt_q == LAST) begin
                div_cnt_d = '0;
                step_en_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            step_en_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            step_en_q <= step_en_d;
        end
    end

    assign step_en = step_en_q;

endmodule

// File: rtl/soc_selftest_monitor.sv
// -----------------------------------------------------------------------------
// soc_selftest_monitor
//   Self-test controller beside the CPU: steps the CPU through a clock enable,
//   watches one debug register for an expected value and reports the outcome.
//   Optional macro: SOC_MON_HALT_DETECT_EN enables halt detection (PC unchanged
//   for HALT_STEPS consecutive steps -> FAIL with FC_HALT).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse to arm / re-arm a run (ignored while running)
//   cpu_bus    : CPU link (step enable, debug address/data, PC), master side
//   pc_nib     : cpu_pc[3:0] for display
//   reg_nib    : dbg_reg_data[3:0] for display
//   steps      : CPU steps issued in the current run, saturating, frozen when done
//   pass, fail : sticky result flags
//   done       : pass | fail, registered
//   fail_code  : FC_NONE / FC_TIMEOUT / FC_HALT
//   state_dbg  : current FSM state
// -----------------------------------------------------------------------------
module soc_selftest_monitor
    import soc_mon_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                REG_IDX    = 10,
    parameter logic [DATA_W-1:0] EXPECTED   = 32'h00213d05,
    parameter int                DIV        = 4,
    parameter int                TIMEOUT_W  = 8,
    parameter int                SETTLE     = 2,
    parameter int                HALT_STEPS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    soc_selftest_monitor_if.master cpu_bus,
    output logic [3:0]             pc_nib,
    output logic [3:0]             reg_nib,
    output logic [TIMEOUT_W-1:0]   steps,
    output logic                   pass,
    output logic                   fail,
    output logic                   done,
    output fail_code_t             fail_code,
    output mon_state_t             state_dbg
);

    localparam int            MW        = $clog2(SETTLE + 1);
    localparam logic [MW-1:0] SETTLE_M1 = MW'(SETTLE - 1);

    mon_state_t           state_q, state_d;
    logic [TIMEOUT_W-1:0] steps_q, steps_d;
    logic [MW-1:0]        match_q, match_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 done_q, done_d;
    fail_code_t           fail_code_q, fail_code_d;

    logic step_en;
    logic run_en;
    logic data_match;
    logic pass_hit;
    logic timeout_hit;
    logic halt_hit;

    assign data_match  = (cpu_bus.dbg_reg_data == EXPECTED);
    // The sample in this cycle completes the run of SETTLE consecutive matches.
    assign pass_hit    = data_match && (match_q == SETTLE_M1);
    assign timeout_hit = (steps_q == '1);

    // Divider runs only while the FSM stays in RUN, so no step pulse can leak
    // into the PASS/FAIL state and the divider restarts from 0 on every run.
    assign run_en = (state_q == RUN) && (state_d == RUN);

    soc_mon_step_gen #(
        .DIV (DIV)
    ) u_step_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (run_en),
        .step_en (step_en)
    );

`ifdef SOC_MON_HALT_DETECT_EN
    localparam int            HW       = $clog2(HALT_STEPS + 1);
    localparam logic [HW-1:0] HALT_M1  = HW'(HALT_STEPS - 1);
    localparam logic [HW-1:0] HALT_MAX = HW'(HALT_STEPS);

    logic [DATA_W-1:0] pc_last_q, pc_last_d;
    logic              pc_valid_q, pc_valid_d;
    logic [HW-1:0]     halt_q, halt_d;
    logic              pc_same;

    // The first step of a run only captures the PC; comparisons start after.
    assign pc_same  = pc_valid_q && (cpu_bus.cpu_pc == pc_last_q);
    assign halt_hit = step_en && pc_same && (halt_q == HALT_M1);

    always_comb begin
        pc_last_d  = pc_last_q;
        pc_valid_d = pc_valid_q;
        halt_d     = halt_q;
        if (state_q != RUN) begin
            pc_last_d  = '0;
            pc_valid_d = 1'b0;
            halt_d     = '0;
        end else if (step_en) begin
            pc_last_d  = cpu_bus.cpu_pc;
            pc_valid_d = 1'b1;
            if (!pc_same) begin
                halt_d = '0;
            end else if (halt_q != HALT_MAX) begin
                halt_d = halt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_last_q  <= '0;
            pc_valid_q <= 1'b0;
            halt_q     <= '0;
        end else begin
            pc_last_q  <= pc_last_d;
            pc_valid_q <= pc_valid_d;
            halt_q     <= halt_d;
        end
    end
`else
    logic unused_pc_hi;
    logic unused_halt_cfg;

    assign halt_hit        = 1'b0;
    assign unused_pc_hi    = ^cpu_bus.cpu_pc[DATA_W-1:4];
    assign unused_halt_cfg = (HALT_STEPS > 0);
`endif

    // FSM next state and result flags. A pass seen in the same cycle as a halt
    // or timeout takes priority.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        done_d      = done_q;
        fail_code_d = fail_code_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pass_hit) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (halt_hit) begin
                    state_d     = FAIL;
                    fail_d      = 1'b1;
                    done_d      = 1'b1;
                    fail_code_d = FC_HALT;
                end else if (timeout_hit) begin
                    state_d     = FAIL;
                    fail_d      = 1'b1;
                    done_d      = 1'b1;
                    fail_code_d = FC_TIMEOUT;
                end
            end
            PASS, FAIL: begin
                if (start) begin
                    state_d     = RUN;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    done_d      = 1'b0;
                    fail_code_d = FC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step and match counters.
    always_comb begin
        steps_d = steps_q;
        match_d = '0;
        if ((state_q != RUN) && (state_d == RUN)) begin
            steps_d = '0;
        end else if ((state_q == RUN) && step_en && (steps_q != '1)) begin
            steps_d = steps_q + 1'b1;
        end
        if ((state_q == RUN) && data_match) begin
            match_d = match_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            steps_q     <= '0;
            match_q     <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            match_q     <= match_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign cpu_bus.cpu_step_en  = step_en;
    assign cpu_bus.dbg_reg_addr = DBG_ADDR_W'(REG_IDX);
    assign pc_nib               = cpu_bus.cpu_pc[3:0];
    assign reg_nib              = cpu_bus.dbg_reg_data[3:0];
    assign steps                = steps_q;
    assign pass                 = pass_q;
    assign fail                 = fail_q;
    assign done                 = done_q;
    assign fail_code            = fail_code_q;
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_soc_selftest_monitor.sv
// -----------------------------------------------------------------------------
// tb_soc_selftest_monitor
//   Drives per-cycle debug data / PC traces into the monitor and compares its
//   outputs with outcomes derived from the trace: cycle of the SETTLE-th
//   consecutive match, timeout cycle, and (with SOC_MON_HALT_DETECT_EN) the
//   step at which HALT_STEPS equal PC comparisons have accumulated.
//   RUN cycle r = 1 is the first clk after the edge that samples start.
// -----------------------------------------------------------------------------
module tb_soc_selftest_monitor;
    import soc_mon_pkg::*;

    localparam int                DATA_W     = 32;
    localparam int                REG_IDX    = 10;
    localparam logic [DATA_W-1:0] EXPECTED   = 32'h00213d05;
    localparam int                DIV        = 4;
    localparam int                TW         = 4;
    localparam int                SETTLE     = 2;
    localparam int                HALT_STEPS = 3;
    localparam int                MAX_R      = 70;
    localparam int                NEVER      = 1000;
    localparam int                STEPS_MAX  = (1 << TW) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic [3:0]    pc_nib;
    logic [3:0]    reg_nib;
    logic [TW-1:0] steps;
    logic          pass;
    logic          fail;
    logic          done;
    fail_code_t    fail_code;
    mon_state_t    state_dbg;

    soc_selftest_monitor_if #(.DATA_W(DATA_W)) mon_if ();

    soc_selftest_monitor #(
        .DATA_W     (DATA_W),
        .REG_IDX    (REG_IDX),
        .EXPECTED   (EXPECTED),
        .DIV        (DIV),
        .TIMEOUT_W  (TW),
        .SETTLE     (SETTLE),
        .HALT_STEPS (HALT_STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cpu_bus   (mon_if.master),
        .pc_nib    (pc_nib),
        .reg_nib   (reg_nib),
        .steps     (steps),
        .pass      (pass),
        .fail      (fail),
        .done      (done),
        .fail_code (fail_code),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fails  = 0;

    logic [DATA_W-1:0] m_data [0:MAX_R];
    logic [DATA_W-1:0] m_pc   [0:MAX_R];
    logic [TW-1:0]     exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fill the trace arrays. 0: always match, 1: never match, 2: match 1,0,1,1,
    // 3: PC stuck at 0x1C, 4: match only in cycles 61/62, 5: random.
    task automatic fill(input int mode);
        int dens;
        dens = $urandom_range(0, 3);
        for (int r = 0; r <= MAX_R; r++) begin
            m_data[r] = EXPECTED ^ DATA_W'(r + 1);
            m_pc[r]   = DATA_W'(32'h100 + 4 * r);
            case (mode)
                0: m_data[r] = EXPECTED;
                2: if (r == 1 || r == 3 || r == 4) m_data[r] = EXPECTED;
                3: m_pc[r] = 32'h1C;
                4: if (r == 61 || r == 62) m_data[r] = EXPECTED;
                5: begin
                    m_data[r] = ($urandom_range(0, 15) < dens) ? EXPECTED : $urandom;
                    m_pc[r]   = ($urandom_range(0, 9) < 7) ? 32'h40 : $urandom;
                end
                default: ;
            endcase
        end
    endtask

    // Reference model: outcome of one run from the whole trace.
    task automatic predict(output int r_end, output logic exp_pass,
                           output logic [1:0] exp_code, output int exp_steps);
        int  r_pass;
        int  r_halt;
        int  r_to;
        int  run;
        int  s;
        logic same;
        r_pass = NEVER;
        r_halt = NEVER;
        run    = 0;
        for (int r = 1; r <= MAX_R; r++) begin
            run = (m_data[r] == EXPECTED) ? run + 1 : 0;
            if (run >= SETTLE && r_pass == NEVER) r_pass = r;
        end
        // steps reaches all-ones in the cycle after pulse number STEPS_MAX.
        r_to = STEPS_MAX * DIV + 2;
`ifdef SOC_MON_HALT_DETECT_EN
        // Step j is issued in RUN cycle j*DIV+1.
        for (int j = HALT_STEPS + 1; j * DIV + 1 <= MAX_R; j++) begin
            same = 1'b1;
            for (int k = 1; k <= HALT_STEPS; k++) begin
                if (m_pc[(j - k) * DIV + 1] != m_pc[(j - k + 1) * DIV + 1]) same = 1'b0;
            end
            if (same && r_halt == NEVER) r_halt = j * DIV + 1;
        end
`endif
        if (r_pass <= r_to && r_pass <= r_halt) begin
            r_end = r_pass; exp_pass = 1'b1; exp_code = 2'b00;
        end else if (r_halt < r_to) begin
            r_end = r_halt; exp_pass = 1'b0; exp_code = 2'b10;
        end else begin
            r_end = r_to;   exp_pass = 1'b0; exp_code = 2'b01;
        end
        exp_steps = (r_end - 1) / DIV;
        if (exp_steps > STEPS_MAX) exp_steps = STEPS_MAX;
        exp_q.delete();
        for (int r = 1; r <= r_end + 4; r++) begin
            s = (r > r_end) ? exp_steps : ((r >= 2) ? (r - 2) / DIV : 0);
            if (s > STEPS_MAX) s = STEPS_MAX;
            exp_q.push_back(TW'(s));
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_run(input string name, input int start_at);
        int            r_end;
        int            exp_steps;
        logic          exp_pass;
        logic [1:0]    exp_code;
        logic [TW-1:0] exp_s;
        logic          exp_step;
        predict(r_end, exp_pass, exp_code, exp_steps);
        @(posedge clk); #1;
        start = 1'b1;
        mon_if.dbg_reg_data = ~EXPECTED;
        mon_if.cpu_pc       = m_pc[0];
        @(posedge clk); #1;
        for (int r = 1; r <= r_end + 4; r++) begin
            start = (r == start_at) && (r <= r_end);
            mon_if.dbg_reg_data = m_data[r];
            mon_if.cpu_pc       = m_pc[r];
            @(negedge clk);
            exp_s    = exp_q.pop_front();
            exp_step = (r > 1) && ((r - 1) % DIV == 0) && (r <= r_end);
            check_val({name, ":steps"},   steps, exp_s);
            check_val({name, ":step_en"}, mon_if.cpu_step_en, exp_step);
            check_val({name, ":done"},    done, r > r_end);
            check_val({name, ":pc_nib"},  pc_nib, m_pc[r][3:0]);
            check_val({name, ":reg_nib"}, reg_nib, m_data[r][3:0]);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_val({name, ":pass"},      pass, exp_pass);
        check_val({name, ":fail"},      fail, !exp_pass);
        check_val({name, ":fail_code"}, fail_code, exp_code);
        check_val({name, ":steps_fin"}, steps, exp_steps);
        check_val({name, ":state"},     state_dbg, exp_pass ? PASS : FAIL);
    endtask

    task automatic check_idle(input string name);
        check_val({name, ":state"},     state_dbg, IDLE);
        check_val({name, ":steps"},     steps, 0);
        check_val({name, ":pass"},      pass, 0);
        check_val({name, ":fail"},      fail, 0);
        check_val({name, ":done"},      done, 0);
        check_val({name, ":fail_code"}, fail_code, 0);
        check_val({name, ":step_en"},   mon_if.cpu_step_en, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mon_if.dbg_reg_data = '0;
        mon_if.cpu_pc       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check_val("dbg_reg_addr", mon_if.dbg_reg_addr, REG_IDX);
        rst_n = 1'b1;

        fill(0); drive_run("always_match", 0);
        fill(1); drive_run("timeout", 3);
        fill(2); drive_run("toggle_1011", 0);
        fill(3); drive_run("pc_stuck", 0);
        fill(4); drive_run("late_match", 0);

        // Abort a run with reset after 10 RUN cycles (two steps issued).
        fill(1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            mon_if.dbg_reg_data = m_data[r];
            mon_if.cpu_pc       = m_pc[r];
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_val("pre_abort:steps", steps, 2);
        check_val("pre_abort:done",  done, 0);
        rst_n = 1'b0;
        #2;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        fill(2); drive_run("after_reset", 0);

        for (int i = 0; i < 8; i++) begin
            fill(5);
            drive_run($sformatf("random%0d", i), $urandom_range(1, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
